// File: rtl/alarm_sequencer_if.sv
// alarm_sequencer_if: groups the time compare inputs, button pulses and alarm control outputs.
// Latency: none. This is wiring only.
// Backpressure: none. All inputs are levels or one-clk pulses, and the master owns the inputs.
interface alarm_sequencer_if;
    logic       sec_tick;
    logic [1:0] cur_h1;
    logic [3:0] cur_h2;
    logic [2:0] cur_m1;
    logic [3:0] cur_m2;
    logic [1:0] alm_h1;
    logic [3:0] alm_h2;
    logic [2:0] alm_m1;
    logic [3:0] alm_m2;
    logic       alarm_en;
    logic       adjust;
    logic       stop_req;
    logic       snooze_req;
    logic       alarm_on;
    logic       snooze_en;
    logic       snooze_rst;
    logic       missed;
    logic [1:0] snooze_cnt;

    modport master (
        output sec_tick, cur_h1, cur_h2, cur_m1, cur_m2,
               alm_h1, alm_h2, alm_m1, alm_m2,
               alarm_en, adjust, stop_req, snooze_req,
        input  alarm_on, snooze_en, snooze_rst, missed, snooze_cnt
    );

    modport slave (
        input  sec_tick, cur_h1, cur_h2, cur_m1, cur_m2,
               alm_h1, alm_h2, alm_m1, alm_m2,
               alarm_en, adjust, stop_req, snooze_req,
        output alarm_on, snooze_en, snooze_rst, missed, snooze_cnt
    );
endinterface

// File: rtl/alarm_sequencer.sv
// alarm_sequencer: decides when the alarm rings, snoozes, times out and stops, using a BCD time compare and a 1 Hz tick.
// Latency: every output is registered and changes 1 clk after the deciding edge. Defining SNOOZE_LIMIT_EN caps snoozes at MAX_SNOOZE.
// Backpressure: none. Pulse inputs are sampled on every clk, and a pulse that the current state does not use is dropped.
module alarm_sequencer #(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int MAX_SNOOZE  = 3,
    parameter int CNT_W       = 9
) (
    input  logic              clk,
    input  logic              rst,
    alarm_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {ST_IDLE, ST_RINGING, ST_SNOOZE, ST_DONE} state_t;

    localparam logic [CNT_W-1:0] RING_LAST = CNT_W'(RING_SECS - 1);
    localparam logic [CNT_W-1:0] SNZ_LAST  = CNT_W'(SNOOZE_SECS - 1);

    // Reject parameter sets that would let the counters wrap or overflow the 2-bit snooze count.
    if ((RING_SECS < 1) || (SNOOZE_SECS < 1) ||
        ((1 << CNT_W) <= RING_SECS) || ((1 << CNT_W) <= SNOOZE_SECS) ||
        (MAX_SNOOZE < 1) || (MAX_SNOOZE > 3)) begin : g_bad_params
        $error("alarm_sequencer: illegal parameter set");
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] ring_cnt_q, ring_cnt_d;
    logic [CNT_W-1:0] snz_cnt_q, snz_cnt_d;
    logic [1:0]       snooze_cnt_q, snooze_cnt_d;
    logic             missed_q, missed_d;
    logic             match_q;
    logic             alarm_on_q, alarm_on_d;
    logic             snooze_en_q, snooze_en_d;
    logic             snooze_rst_q, snooze_rst_d;

    logic match, trigger, abort, snooze_limit_hit;

    // Trigger on the rising edge of the match, so holding the alarm minute never re-rings.
    assign match = bus.alarm_en & ~bus.adjust &
                   (bus.cur_h1 == bus.alm_h1) & (bus.cur_h2 == bus.alm_h2) &
                   (bus.cur_m1 == bus.alm_m1) & (bus.cur_m2 == bus.alm_m2);
    assign trigger = match & ~match_q;
    assign abort   = ~bus.alarm_en | bus.adjust;

`ifdef SNOOZE_LIMIT_EN
    localparam logic [1:0] SNZ_LIMIT = 2'(MAX_SNOOZE);
    assign snooze_limit_hit = (snooze_cnt_q == SNZ_LIMIT);
`else
    assign snooze_limit_hit = 1'b0;
`endif

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            ring_cnt_q   <= '0;
            snz_cnt_q    <= '0;
            snooze_cnt_q <= 2'd0;
            missed_q     <= 1'b0;
            match_q      <= 1'b0;
            alarm_on_q   <= 1'b0;
            snooze_en_q  <= 1'b0;
            snooze_rst_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ring_cnt_q   <= ring_cnt_d;
            snz_cnt_q    <= snz_cnt_d;
            snooze_cnt_q <= snooze_cnt_d;
            missed_q     <= missed_d;
            match_q      <= match;
            alarm_on_q   <= alarm_on_d;
            snooze_en_q  <= snooze_en_d;
            snooze_rst_q <= snooze_rst_d;
        end
    end

    // Next state. The aborts take priority, then stop, then snooze, then the tick or timeout.
    always_comb begin
        state_d      = state_q;
        ring_cnt_d   = ring_cnt_q;
        snz_cnt_d    = snz_cnt_q;
        snooze_cnt_d = snooze_cnt_q;
        missed_d     = missed_q;

        // A stop press always acknowledges a missed alarm, whatever the state.
        if (bus.stop_req) begin
            missed_d = 1'b0;
        end

        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (trigger) begin
                        state_d      = ST_RINGING;
                        ring_cnt_d   = '0;
                        snooze_cnt_d = 2'd0;
                    end
                end
                ST_RINGING: begin
                    if (bus.stop_req || (bus.snooze_req && snooze_limit_hit)) begin
                        state_d = ST_DONE;
                    end else if (bus.snooze_req) begin
                        state_d   = ST_SNOOZE;
                        snz_cnt_d = '0;
                        if (snooze_cnt_q != 2'd3) begin
                            snooze_cnt_d = snooze_cnt_q + 2'd1;
                        end
                    end else if (bus.sec_tick) begin
                        if (ring_cnt_q == RING_LAST) begin
                            state_d  = ST_DONE;
                            missed_d = 1'b1;
                        end else begin
                            ring_cnt_d = ring_cnt_q + 1'b1;
                        end
                    end
                end
                ST_SNOOZE: begin
                    if (bus.stop_req) begin
                        state_d = ST_DONE;
                    end else if (bus.sec_tick) begin
                        if (snz_cnt_q == SNZ_LAST) begin
                            state_d    = ST_RINGING;
                            ring_cnt_d = '0;
                        end else begin
                            snz_cnt_d = snz_cnt_q + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    // Hold until the time leaves the alarm minute, so a stop cannot re-ring within it.
                    if (!match) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output decode from the next state, so each output is registered alongside the state.
    always_comb begin
        alarm_on_d   = (state_d == ST_RINGING);
        snooze_en_d  = (state_d == ST_SNOOZE);
        snooze_rst_d = (state_q == ST_RINGING) && (state_d == ST_SNOOZE);
    end

    assign bus.alarm_on   = alarm_on_q;
    assign bus.snooze_en  = snooze_en_q;
    assign bus.snooze_rst = snooze_rst_q;
    assign bus.missed     = missed_q;
    assign bus.snooze_cnt = snooze_cnt_q;

endmodule
